pll_ctrl: RTL and testbench

Reset and lock sequencer for the rPLL that generates the CNN fabric clock. It runs on the 27 MHz board reference clock and drives the PLL `RESET` pin. It waits for a stable `LOCK`, then releases a clean active-low system reset to the CNN datapath. It recovers from lock loss by retrying, and it applies dynamic divider settings (`IDSEL`/`FBDSEL`/`ODSEL`) through a req/ack handshake.

---
 rtl/pll_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pll_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_ctrl.sv
// pll_ctrl: reset/lock sequencer for the rPLL feeding the CNN fabric clock.
// Runs on the 27 MHz reference clock. It pulses the PLL RESET, waits for a
// stable LOCK and then releases sys_rst_n. On LOCK loss it retries.
// Optional build macro PLL_CTRL_DYN_CFG_EN enables the CFG state and the
// req/ack handshake for dynamic IDSEL/FBDSEL/ODSEL updates. Without the macro,
// the cfg_* inputs are ignored, cfg_ack is 0 and the selects stay at *_INIT.
// Ports:
//   clk, rst_n                      - reference clock, async active-low reset
//   pll_lock                        - raw PLL LOCK (async, 2-FF synchronised)
//   cfg_req/cfg_*sel/cfg_ack        - level request, new selects, 1-cycle ack
//   pll_reset, pll_*sel             - PLL RESET pin and dynamic selects
//   sys_rst_n, locked, fault        - fabric reset, RUN indicator, sticky fault
//   relock_cnt                      - saturating count of lock losses in RUN
module pll_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  IDSEL_INIT   = 6'd0,
  parameter logic [5:0]  FBDSEL_INIT  = 6'd0,
  parameter logic [5:0]  ODSEL_INIT   = 6'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ack,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [7:0] relock_cnt
);

  localparam int CW = 17;
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]    RETRY_MAX    = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET, ST_WAIT_LOCK, ST_STABLE, ST_RUN, ST_CFG, ST_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    retry;
  logic          lock_s1;
  logic          lock_sync;

`ifdef PLL_CTRL_DYN_CFG_EN
  logic       ack_q;
  logic [5:0] idsel_q;
  logic [5:0] fbdsel_q;
  logic [5:0] odsel_q;
  assign cfg_ack    = ack_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel};
  assign cfg_ack    = 1'b0;
  assign pll_idsel  = IDSEL_INIT;
  assign pll_fbdsel = FBDSEL_INIT;
  assign pll_odsel  = ODSEL_INIT;
`endif

  // LOCK comes from the PLL's own clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1   <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_s1   <= pll_lock;
      lock_sync <= lock_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      cnt        <= '0;
      retry      <= '0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      relock_cnt <= '0;
`ifdef PLL_CTRL_DYN_CFG_EN
      ack_q      <= 1'b0;
      idsel_q    <= IDSEL_INIT;
      fbdsel_q   <= FBDSEL_INIT;
      odsel_q    <= ODSEL_INIT;
`endif
    end else begin
`ifdef PLL_CTRL_DYN_CFG_EN
      ack_q <= 1'b0;
`endif
      case (state)
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync) begin
            // The cycle that saw lock counts as the first stable cycle.
            state <= ST_STABLE;
            cnt   <= CW'(1);
          end else if (cnt == TIMEOUT_LAST) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry     <= retry + 8'd1;
            if (retry + 8'd1 == RETRY_MAX) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              state <= ST_RESET;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_sync) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt >= STABLE_LAST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            retry     <= '0;
            sys_rst_n <= 1'b1;
            locked    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          // Lock loss wins over a simultaneous cfg_req.
          if (!lock_sync) begin
            state     <= ST_RESET;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
          end
`ifdef PLL_CTRL_DYN_CFG_EN
          else if (cfg_req) begin
            state     <= ST_CFG;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            ack_q     <= 1'b1;
            idsel_q   <= cfg_idsel;
            fbdsel_q  <= cfg_fbdsel;
            odsel_q   <= cfg_odsel;
          end
`endif
        end
        ST_CFG: begin
          // New selects are already on the PLL; relock from scratch.
          state     <= ST_RESET;
          cnt       <= '0;
          pll_reset <= 1'b1;
        end
        ST_FAULT: begin
`ifdef PLL_CTRL_DYN_CFG_EN
          if (cfg_req) begin
            state    <= ST_CFG;
            retry    <= '0;
            fault    <= 1'b0;
            ack_q    <= 1'b1;
            idsel_q  <= cfg_idsel;
            fbdsel_q <= cfg_fbdsel;
            odsel_q  <= cfg_odsel;
          end
`endif
        end
        default: begin
          state     <= ST_RESET;
          cnt       <= '0;
          pll_reset <= 1'b1;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: randomized self-checking bench for pll_ctrl.
// Expected timings come from the sequencer rules as plain arithmetic on the
// bench parameters; selects and relock count are tracked in a small model.
module tb_pll_ctrl;

  localparam int RST_CYC = 4;
  localparam int STAB    = 8;
  localparam int TMO     = 32;
  localparam int MAXR    = 2;
  localparam logic [5:0] ID_INIT = 6'd1;
  localparam logic [5:0] FB_INIT = 6'd2;
  localparam logic [5:0] OD_INIT = 6'd3;

  localparam int S_PRST = 0;
  localparam int S_SRST = 1;
  localparam int S_ACK  = 2;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       cfg_req;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic       cfg_ack;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [7:0] relock_cnt;

  int errors = 0;
  int checks = 0;
  int losses = 0;
  logic [5:0] exp_id = ID_INIT;
  logic [5:0] exp_fb = FB_INIT;
  logic [5:0] exp_od = OD_INIT;

  pll_ctrl #(
    .RST_CYCLES(RST_CYC), .LOCK_STABLE(STAB), .LOCK_TIMEOUT(TMO), .MAX_RETRY(MAXR),
    .IDSEL_INIT(ID_INIT), .FBDSEL_INIT(FB_INIT), .ODSEL_INIT(OD_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .cfg_ack(cfg_ack), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault), .relock_cnt(relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      S_PRST:  return pll_reset;
      S_SRST:  return sys_rst_n;
      S_ACK:   return cfg_ack;
      default: return 1'bx;
    endcase
  endfunction

  function automatic int sat_relock(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples already on a negedge; returns number of negedges until sig==v.
  task automatic wait_sig(input string tag, input int w, input logic v,
                          input int budget, output int n);
    n = 0;
    while (sig(w) !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(w) !== v) check({tag, "_reached"}, 32'(sig(w)), 32'(v));
  endtask

  // Counts consecutive samples (including the current one) with sig==v.
  task automatic run_len(input int w, input logic v, input int budget, output int n);
    n = 0;
    while (sig(w) === v && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_sel(input string tag);
    check({tag, "_idsel"},  32'(pll_idsel),  32'(exp_id));
    check({tag, "_fbdsel"}, 32'(pll_fbdsel), 32'(exp_fb));
    check({tag, "_odsel"},  32'(pll_odsel),  32'(exp_od));
  endtask

  task automatic check_rst(input string tag);
    exp_id = ID_INIT; exp_fb = FB_INIT; exp_od = OD_INIT;
    check({tag, "_pll_reset"},  32'(pll_reset),  32'd1);
    check({tag, "_sys_rst_n"},  32'(sys_rst_n),  32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_cfg_ack"},    32'(cfg_ack),    32'd0);
    check({tag, "_fault"},      32'(fault),      32'd0);
    check({tag, "_relock_cnt"}, 32'(relock_cnt), 32'd0);
    check_sel(tag);
  endtask

  task automatic drive_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    cfg_idsel = i; cfg_fbdsel = f; cfg_odsel = o; cfg_req = 1'b1;
  endtask

  initial begin
    int n;
    int len;
    logic [5:0] ri, rf, ro;
    rst_n = 1'b0; pll_lock = 1'b0; cfg_req = 1'b0;
    cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
    step(3);
    check_rst("reset");

    // Clean start: lock rises 10 cycles after release.
    rst_n = 1'b1;
    run_len(S_PRST, 1'b1, 20, n);
    check("start_prst_len", n, RST_CYC);
    step(10 - RST_CYC);
    pll_lock = 1'b1;
    wait_sig("start_run", S_SRST, 1'b1, 40, n);
    check("start_run_delay", n, 2 + STAB);
    check("start_locked", 32'(locked), 1);
    check("start_fault", 32'(fault), 0);

    // First lock loss in RUN.
    pll_lock = 1'b0;
    wait_sig("loss", S_SRST, 1'b0, 20, n);
    losses++;
    check("loss_delay", n, 3);
    check("loss_locked", 32'(locked), 0);
    check("loss_relock", 32'(relock_cnt), sat_relock(losses));
    run_len(S_PRST, 1'b1, 20, n);
    check("loss_prst_len", n, RST_CYC);

    // Short lock glitches never reach RUN and cause no retry.
    for (int g = 0; g < 3; g++) begin
      step($urandom_range(1, 4));
      len = $urandom_range(1, STAB - 1);
      pll_lock = 1'b1;
      step(len);
      pll_lock = 1'b0;
      step(4);
      check("glitch_sys_rst_n", 32'(sys_rst_n), 0);
      check("glitch_pll_reset", 32'(pll_reset), 0);
    end
    pll_lock = 1'b1;
    wait_sig("glitch_run", S_SRST, 1'b1, 40, n);
    check("glitch_run_delay", n, 2 + STAB);

`ifdef PLL_CTRL_DYN_CFG_EN
    // Reconfiguration from RUN: fixed values, then random ones.
    for (int k = 0; k < 3; k++) begin
      step($urandom_range(1, 3));
      if (k == 0) begin ri = 6'd5; rf = 6'd9; ro = 6'd12; end
      else begin ri = 6'($urandom); rf = 6'($urandom); ro = 6'($urandom); end
      drive_cfg(ri, rf, ro);
      step(1);
      exp_id = ri; exp_fb = rf; exp_od = ro;
      check("cfg_ack", 32'(cfg_ack), 1);
      check("cfg_sys_rst_n", 32'(sys_rst_n), 0);
      check("cfg_prst_same", 32'(pll_reset), 0);
      check_sel("cfg");
      cfg_req = 1'b0;
      step(1);
      check("cfg_ack_pulse", 32'(cfg_ack), 0);
      run_len(S_PRST, 1'b1, 20, n);
      check("cfg_prst_len", n, RST_CYC);
      wait_sig("cfg_relock", S_SRST, 1'b1, 40, n);
      check("cfg_relock_delay", n, STAB);
    end

    // Request raised during WAIT_LOCK stays pending until RUN.
    pll_lock = 1'b0;
    wait_sig("pend_loss", S_SRST, 1'b0, 20, n);
    losses++;
    run_len(S_PRST, 1'b1, 20, n);
    ri = 6'($urandom); rf = 6'($urandom); ro = 6'($urandom);
    drive_cfg(ri, rf, ro);
    step(3);
    check("pend_no_ack", 32'(cfg_ack), 0);
    pll_lock = 1'b1;
    wait_sig("pend_ack", S_ACK, 1'b1, 40, n);
    check("pend_ack_delay", n, 2 + STAB + 1);
    exp_id = ri; exp_fb = rf; exp_od = ro;
    check_sel("pend");
    cfg_req = 1'b0;
    wait_sig("pend_relock", S_SRST, 1'b1, 60, n);
    check("pend_relock_delay", n, 1 + RST_CYC + STAB);
`else
    // Without dynamic config the request is ignored.
    step(2);
    drive_cfg(6'($urandom), 6'($urandom), 6'($urandom));
    step(5);
    check("nocfg_ack", 32'(cfg_ack), 0);
    check("nocfg_sys_rst_n", 32'(sys_rst_n), 1);
    check_sel("nocfg");
    cfg_req = 1'b0;
`endif

    // Repeated lock losses: relock_cnt saturates at 255.
    while (losses < 300) begin
      pll_lock = 1'b0;
      wait_sig("many_loss", S_SRST, 1'b0, 20, n);
      losses++;
      check("many_loss_delay", n, 3);
      check("many_relock", 32'(relock_cnt), sat_relock(losses));
      step($urandom_range(0, 3));
      pll_lock = 1'b1;
      wait_sig("many_run", S_SRST, 1'b1, 60, n);
    end
    check("relock_sat", 32'(relock_cnt), 255);

    // Timeout and fault with lock held low.
    @(negedge clk);
    rst_n = 1'b0; pll_lock = 1'b0;
    step(1);
    rst_n = 1'b1;
    losses = 0;
    run_len(S_PRST, 1'b1, 20, n);
    check("tmo_prst1", n, RST_CYC);
    run_len(S_PRST, 1'b0, 100, n);
    check("tmo_wait1", n, TMO);
    check("tmo_fault_early", 32'(fault), 0);
    run_len(S_PRST, 1'b1, 20, n);
    check("tmo_prst2", n, RST_CYC);
    run_len(S_PRST, 1'b0, 100, n);
    check("tmo_wait2", n, TMO);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_sys_rst_n", 32'(sys_rst_n), 0);
    run_len(S_PRST, 1'b1, 50, n);
    check("tmo_prst_held", n, 50);
    check("tmo_fault_held", 32'(fault), 1);

`ifdef PLL_CTRL_DYN_CFG_EN
    ri = 6'($urandom); rf = 6'($urandom); ro = 6'($urandom);
    drive_cfg(ri, rf, ro);
    step(1);
    exp_id = ri; exp_fb = rf; exp_od = ro;
    check("fault_cfg_ack", 32'(cfg_ack), 1);
    check("fault_cleared", 32'(fault), 0);
    check_sel("fault_cfg");
    cfg_req = 1'b0;
`else
    drive_cfg(6'($urandom), 6'($urandom), 6'($urandom));
    step(5);
    check("fault_nocfg_ack", 32'(cfg_ack), 0);
    check("fault_sticky", 32'(fault), 1);
    cfg_req = 1'b0;
`endif

    // Asynchronous reset in the middle of STABLE.
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; pll_lock = 1'b1;
    run_len(S_PRST, 1'b1, 20, n);
    check("async_prst_len", n, RST_CYC);
    step(3);
    check("async_pre_sys_rst_n", 32'(sys_rst_n), 0);
    check("async_pre_pll_reset", 32'(pll_reset), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_rst("async");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
